// File: rtl/dp_sequencer.sv
// rtl/dp_sequencer.sv - program-memory command sequencer for the register-file datapath
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   prog_we/prog_addr/prog_wdata  program memory write port (IDLE only)
//   start                      begin execution at address 0
//   busy, done, err, ovf_flag  run status (done is a one-cycle pulse)
//   issued_cnt                 ops driven to the datapath in the last/current run
//   op/src1/src2/dest/ext_data1/ext_data2  datapath command, one op then one NOP
//   overflow                   datapath overflow, valid the cycle after an op
//
// Build option: DP_SEQ_OVF_HALT_EN - an overflow aborts the run and sets err.
module dp_sequencer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = 17
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [31:0]   prog_wdata,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          ovf_flag,
    output logic [AW:0]   issued_cnt,
    output logic [2:0]    op,
    output logic [3:0]    src1,
    output logic [3:0]    src2,
    output logic [3:0]    dest,
    output logic [DW-1:0] ext_data1,
    output logic [DW-1:0] ext_data2,
    input  logic          overflow
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_SAMPLE,
        S_DONE
    } state_t;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_LOAD1 = 3'b010;
    localparam logic [2:0] OP_LOAD2 = 3'b011;
    localparam logic [2:0] OP_HALT  = 3'b101;

    state_t        state;
    logic [AW-1:0] pc;
    logic          halt_r;
    logic [31:0]   mem [DEPTH];
    logic [31:0]   word;
    logic [2:0]    word_op;

    assign word    = mem[pc];
    assign word_op = word[31:29];

    // Program memory is not reset; writes land only while idle.
    always_ff @(posedge clk) begin
        if (prog_we && state == S_IDLE) begin
            mem[prog_addr] <= prog_wdata;
        end
    end

`ifdef DP_SEQ_OVF_HALT_EN
    logic err_r;
    assign err = err_r;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            pc         <= '0;
            halt_r     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            ovf_flag   <= 1'b0;
            issued_cnt <= '0;
            op         <= OP_NOP;
            src1       <= '0;
            src2       <= '0;
            dest       <= '0;
            ext_data1  <= '0;
            ext_data2  <= '0;
`ifdef DP_SEQ_OVF_HALT_EN
            err_r      <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        ovf_flag   <= 1'b0;
                        issued_cnt <= '0;
                        pc         <= '0;
                        busy       <= 1'b1;
                        state      <= S_FETCH;
`ifdef DP_SEQ_OVF_HALT_EN
                        err_r      <= 1'b0;
`endif
                    end
                end
                S_FETCH: begin
                    // The command registers are the memory's read register, so the
                    // decoded word appears on the outputs exactly in the ISSUE cycle.
                    if (word_op == OP_HALT) begin
                        halt_r <= 1'b1;
                    end else begin
                        halt_r    <= 1'b0;
                        op        <= word_op;
                        src1      <= word[28:25];
                        src2      <= word[24:21];
                        dest      <= word[20:17];
                        ext_data1 <= (word_op == OP_LOAD1) ? DW'(word[16:0]) : '0;
                        ext_data2 <= (word_op == OP_LOAD2) ? DW'(word[16:0]) : '0;
                    end
                    state <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (halt_r) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        issued_cnt <= issued_cnt + (AW+1)'(1);
                        op         <= OP_NOP;
                        src1       <= '0;
                        src2       <= '0;
                        dest       <= '0;
                        ext_data1  <= '0;
                        ext_data2  <= '0;
                        state      <= S_SAMPLE;
                    end
                end
                S_SAMPLE: begin
                    if (overflow) begin
                        ovf_flag <= 1'b1;
                    end
`ifdef DP_SEQ_OVF_HALT_EN
                    if (overflow) begin
                        err_r <= 1'b1;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else
`endif
                    if (pc == AW'(DEPTH - 1)) begin
                        // Last slot reached without HALT: stop rather than wrap.
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        pc    <= pc + AW'(1);
                        state <= S_FETCH;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dp_sequencer.sv
// tb/tb_dp_sequencer.sv - self-checking bench for dp_sequencer
module tb_dp_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        prog_we = 1'b0;
    logic [3:0]  prog_addr = '0;
    logic [31:0] prog_wdata = '0;
    logic        start = 1'b0;
    logic        overflow = 1'b0;
    logic        busy, done, err, ovf_flag;
    logic [4:0]  issued_cnt;
    logic [2:0]  op;
    logic [3:0]  src1, src2, dest;
    logic [16:0] ext_data1, ext_data2;

    dp_sequencer #(.DEPTH(16), .AW(4), .DW(17)) dut (
        .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_wdata(prog_wdata), .start(start), .busy(busy), .done(done),
        .err(err), .ovf_flag(ovf_flag), .issued_cnt(issued_cnt), .op(op),
        .src1(src1), .src2(src2), .dest(dest), .ext_data1(ext_data1),
        .ext_data2(ext_data2), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

`ifdef DP_SEQ_OVF_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    // Shadow of what the bench believes program memory holds.
    logic [31:0] prog [16];

    // Expected per-cycle view: {op,src1,src2,dest,ext1,ext2,done,busy}
    logic [50:0] exp_q [$];
    bit          ovf_q [$];
    int          m_cnt;
    bit          m_ovf, m_err;
    logic [48:0] snap;

    function automatic logic [31:0] enc(input int o, input int a, input int b,
                                        input int d, input int imm);
        logic [31:0] w;
        w = {3'(o), 4'(a), 4'(b), 4'(d), 17'(imm)};
        return w;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // Reference: walk the program by the instruction rules and list what each
    // cycle after the start edge must look like. ovf_bits[k] = datapath overflow
    // reported for the k-th issued op.
    task automatic model(input logic [15:0] ovf_bits);
        logic [2:0]  o;
        logic [31:0] w;
        logic [50:0] z;
        int k;
        z = '0;
        z[0] = 1'b1;
        exp_q.delete();
        ovf_q.delete();
        k = 0;
        m_ovf = 0;
        m_err = 0;
        for (int p = 0; p < 16; p++) begin
            w = prog[p];
            o = w[31:29];
            exp_q.push_back(z); ovf_q.push_back(1'b0);
            if (o == 3'b101) begin
                exp_q.push_back(z); ovf_q.push_back(1'b0);
                break;
            end
            exp_q.push_back({o, w[28:25], w[24:21], w[20:17],
                             (o == 3'b010) ? w[16:0] : 17'd0,
                             (o == 3'b011) ? w[16:0] : 17'd0, 1'b0, 1'b1});
            ovf_q.push_back(1'b0);
            exp_q.push_back(z); ovf_q.push_back(ovf_bits[k]);
            if (ovf_bits[k]) m_ovf = 1;
            k++;
            if (HALT_EN && ovf_bits[k-1]) begin
                m_err = 1;
                break;
            end
        end
        exp_q.push_back({49'd0, 1'b1, 1'b1}); ovf_q.push_back(1'b0);
        m_cnt = k;
    endtask

    task automatic load_prog();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            prog_we = 1'b1; prog_addr = 4'(i); prog_wdata = prog[i];
        end
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    // guard_cyc: cycle in which a write to addr 0 and a start are attempted mid-run.
    // wr0: drive prog[0] into address 0 together with start.
    task automatic run_prog(input logic [15:0] ovf_bits, input int guard_cyc,
                            input bit wr0, output int done_cyc);
        logic [50:0] got;
        model(ovf_bits);
        @(negedge clk);
        start = 1'b1;
        if (wr0) begin
            prog_we = 1'b1; prog_addr = 4'd0; prog_wdata = prog[0];
        end
        @(negedge clk);
        start = 1'b0; prog_we = 1'b0;
        done_cyc = -1;
        for (int c = 1; c <= exp_q.size(); c++) begin
            got = {op, src1, src2, dest, ext_data1, ext_data2, done, busy};
            check($sformatf("cycle%0d", c), 64'(got), 64'(exp_q[c-1]));
            if (c == 2) snap = got[50:2];
            if (done) done_cyc = c;
            overflow = ovf_q[c-1];
            if (c == guard_cyc) begin
                prog_we = 1'b1; prog_addr = 4'd0; prog_wdata = ~prog[0]; start = 1'b1;
            end
            @(negedge clk);
            prog_we = 1'b0; start = 1'b0; overflow = 1'b0;
        end
        check("idle_after_done", 64'({busy, done}), 64'(0));
        check("issued_cnt", 64'(issued_cnt), 64'(m_cnt));
        check("ovf_flag", 64'(ovf_flag), 64'(m_ovf));
        check("err", 64'(err), 64'(m_err));
    endtask

    typedef struct {
        logic [31:0] word;
        logic [48:0] want;   // {op,src1,src2,dest,ext1,ext2} in the ISSUE cycle
    } vec_t;

    vec_t vecs [6];
    int   dc;
    int   pulses;

    initial begin
        vecs[0] = '{enc(2, 0, 0, 1, 25),         {3'd2, 4'd0, 4'd0, 4'd1, 17'd25, 17'd0}};
        vecs[1] = '{enc(3, 0, 0, 2, 12),         {3'd3, 4'd0, 4'd0, 4'd2, 17'd0, 17'd12}};
        vecs[2] = '{enc(4, 1, 2, 4, 'h1ABCD),    {3'd4, 4'd1, 4'd2, 4'd4, 17'd0, 17'd0}};
        vecs[3] = '{enc(1, 3, 0, 5, 7),          {3'd1, 4'd3, 4'd0, 4'd5, 17'd0, 17'd0}};
        vecs[4] = '{enc(7, 15, 14, 13, 'h1FFFF), {3'd7, 4'd15, 4'd14, 4'd13, 17'd0, 17'd0}};
        vecs[5] = '{enc(0, 9, 8, 7, 3),          {3'd0, 4'd9, 4'd8, 4'd7, 17'd0, 17'd0}};

        repeat (2) @(negedge clk);
        check("reset_state", 64'({busy, done, err, ovf_flag, issued_cnt, op, src1, src2,
                                  dest, ext_data1, ext_data2}), 64'(0));
        rst_n = 1'b1;

        // Basic run
        for (int i = 0; i < 16; i++) prog[i] = enc(5, 0, 0, 0, 0);
        prog[0] = enc(2, 0, 0, 1, 25);
        prog[1] = enc(3, 0, 0, 2, 12);
        prog[2] = enc(4, 1, 2, 4, 0);
        load_prog();
        run_prog(16'h0, 0, 0, dc);
        check("basic_done_cycle", 64'(dc), 64'(12));

        // COPY / SUB / MUL
        prog[0] = enc(1, 1, 0, 3, 0);
        prog[1] = enc(6, 1, 2, 5, 0);
        prog[2] = enc(7, 1, 2, 6, 0);
        load_prog();
        run_prog(16'h0, 0, 0, dc);
        check("csm_done_cycle", 64'(dc), 64'(12));

        // Overflow reported on the ADD (third op)
        prog[0] = enc(2, 0, 0, 7, 'h1FFFF);
        prog[1] = enc(3, 0, 0, 8, 1);
        prog[2] = enc(4, 7, 8, 9, 0);
        prog[3] = enc(2, 0, 0, 1, 5);
        load_prog();
        run_prog(16'h0004, 0, 0, dc);
        check("ovf_done_cycle", 64'(dc), HALT_EN ? 64'(10) : 64'(15));

        // Table: single-instruction decode
        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < 16; i++) prog[i] = enc(5, 0, 0, 0, 0);
            prog[0] = vecs[v].word;
            load_prog();
            run_prog(16'h0, 0, 0, dc);
            check($sformatf("decode%0d", v), 64'(snap), 64'(vecs[v].want));
        end

        // Implicit halt at the last slot
        for (int i = 0; i < 16; i++) prog[i] = enc(1, 0, 0, 0, 0);
        load_prog();
        run_prog(16'h0, 0, 0, dc);
        check("implicit_done_cycle", 64'(dc), 64'(49));

        // Protocol guards: write and start while busy are both ignored
        for (int i = 0; i < 16; i++) prog[i] = enc(5, 0, 0, 0, 0);
        prog[0] = enc(2, 0, 0, 1, 25);
        prog[1] = enc(3, 0, 0, 2, 12);
        load_prog();
        run_prog(16'h0, 4, 0, dc);
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            if (done || busy) pulses++;
            @(negedge clk);
        end
        check("no_second_run", 64'(pulses), 64'(0));
        run_prog(16'h0, 0, 0, dc);

        // start and prog_we in the same idle cycle: new word is executed
        prog[0] = enc(2, 0, 0, 6, 'h0ABC);
        run_prog(16'h0, 0, 1, dc);

        // Reset during ISSUE
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        check("issue_before_reset", 64'(op), 64'(2));
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("after_reset", 64'({op, busy, done, issued_cnt, ovf_flag, err}), 64'(0));
        run_prog(16'h0, 0, 0, dc);

        // Random programs and overflow patterns
        for (int it = 0; it < 15; it++) begin
            int len;
            int o;
            len = (it == 7) ? 16 : int'($urandom_range(0, 15));
            for (int i = 0; i < 16; i++) begin
                o = int'($urandom_range(0, 6));
                if (o >= 5) o++;
                prog[i] = (i < len) ? enc(o, $urandom, $urandom, $urandom, $urandom)
                                    : enc(5, $urandom, $urandom, $urandom, $urandom);
            end
            load_prog();
            run_prog(16'($urandom & $urandom & $urandom), 0, 0, dc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
